// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] RSP_PONG = 8'h5A;

  localparam int HDR_BYTES = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_WMEM,
    S_RMEM,
    S_RSEND,
    S_RESP
  } state_t;

endpackage

// File: rtl/uart_cmd_responder.sv
// Byte-stream command decoder: parses WRITE/READ/PING frames from a UART
// receiver, drives a simple request/ack memory port and answers on the UART transmitter.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic          is_write, is_write_next;
  logic [2:0]    hdr_cnt, hdr_cnt_next;
  logic [23:0]   addr, addr_next;
  logic [15:0]   len, len_next;
  logic [7:0]    wdata, wdata_next;
  logic [7:0]    rdata, rdata_next;
  logic [7:0]    resp, resp_next;
  logic          overrun, overrun_next;
  logic          resp_armed, resp_armed_next;
  logic [TW-1:0] timer, timer_next;
  logic          err_next;
  logic [15:0]   hdr_len;
  logic          tx_fire;

  // Outputs are pure decodes of registers, so an async reset clears them at once.
  assign busy      = (state != S_IDLE);
  assign mem_req   = (state == S_WMEM) || (state == S_RMEM);
  assign mem_we    = (state == S_WMEM);
  assign mem_addr  = addr;
  assign mem_wdata = wdata;
  assign tx_valid  = (state == S_RSEND) || ((state == S_RESP) && resp_armed);
  assign tx_data   = (state == S_RSEND) ? rdata : resp;
  assign tx_fire   = tx_valid && tx_ready;
  assign hdr_len   = {len[7:0], rx_data};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_next    = state;
    is_write_next = is_write;
    hdr_cnt_next  = hdr_cnt;
    addr_next     = addr;
    len_next      = len;
    wdata_next    = wdata;
    rdata_next    = rdata;
    resp_next     = resp;
    overrun_next  = overrun;
    timer_next    = timer;
    err_next      = 1'b0;

    unique case (state)
      S_IDLE: begin
        timer_next   = '0;
        hdr_cnt_next = '0;
        overrun_next = 1'b0;
        if (rx_valid) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            is_write_next = (rx_data == OP_WRITE);
            state_next    = S_HDR;
          end else if (rx_data == OP_PING) begin
            resp_next  = RSP_PONG;
            state_next = S_RESP;
          end else begin
            resp_next  = RSP_NAK;
            err_next   = 1'b1;
            state_next = S_RESP;
          end
        end
      end

      S_HDR: begin
        if (rx_valid) begin
          // Header bytes arrive MSB first; shift them through {addr, len}.
          {addr_next, len_next} = {addr[15:0], len, rx_data};
          hdr_cnt_next = hdr_cnt + 3'd1;
          timer_next   = '0;
          if (hdr_cnt == 3'(HDR_BYTES - 1)) begin
            if (hdr_len == 16'd0) begin
              resp_next  = RSP_ACK;
              state_next = S_RESP;
            end else begin
              state_next = is_write ? S_WDATA : S_RMEM;
            end
          end
        end else if (timer == T_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      S_WDATA: begin
        if (rx_valid) begin
          wdata_next   = rx_data;
          overrun_next = 1'b0;
          timer_next   = '0;
          state_next   = S_WMEM;
        end else if (timer == T_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      S_WMEM: begin
        if (rx_valid) overrun_next = 1'b1;
        if (mem_ack) begin
          addr_next = addr + 24'd1;
          len_next  = len - 16'd1;
          if (overrun || rx_valid) begin
            err_next   = 1'b1;
            resp_next  = RSP_NAK;
            state_next = S_RESP;
          end else if (len == 16'd1) begin
            resp_next  = RSP_ACK;
            state_next = S_RESP;
          end else begin
            timer_next = '0;
            state_next = S_WDATA;
          end
        end
      end

      S_RMEM: begin
        if (mem_ack) begin
          rdata_next = mem_rdata;
          state_next = S_RSEND;
        end
      end

      S_RSEND: begin
        if (tx_fire) begin
          addr_next = addr + 24'd1;
          len_next  = len - 16'd1;
          if (len == 16'd1) begin
            resp_next  = RSP_ACK;
            state_next = S_RESP;
          end else begin
            state_next = S_RMEM;
          end
        end
      end

      S_RESP: begin
        if (tx_fire) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase

    // The response byte is held back one cycle so tx_valid always drops between bytes.
    resp_armed_next = (state == S_RESP) && (state_next == S_RESP);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      is_write   <= 1'b0;
      hdr_cnt    <= '0;
      addr       <= '0;
      len        <= '0;
      wdata      <= '0;
      rdata      <= '0;
      resp       <= '0;
      overrun    <= 1'b0;
      resp_armed <= 1'b0;
      timer      <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      is_write   <= is_write_next;
      hdr_cnt    <= hdr_cnt_next;
      addr       <= addr_next;
      len        <= len_next;
      wdata      <= wdata_next;
      rdata      <= rdata_next;
      resp       <= resp_next;
      overrun    <= overrun_next;
      resp_armed <= resp_armed_next;
      timer      <= timer_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: PING, WRITE, READ with wrap and tx stall,
// error frames, overrun, inter-byte timeout and reset during a memory request.
module tb_uart_cmd_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  uart_cmd_responder #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model and logs
  logic [7:0]  mem_model [bit [23:0]];
  logic [23:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [23:0] rd_addr_q[$];
  logic [7:0]  tx_q[$];
  int          err_cnt = 0;
  int          err_run = 0;
  int          err_max_run = 0;
  int          ack_delay = 2;
  bit          ack_hold = 1'b0;
  int          req_age = 0;

  // Memory responder: ack raised at a negedge is seen by the DUT at the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      mem_ack = 1'b0;
      req_age = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      req_age = 0;
    end else if (mem_req) begin
      req_age++;
      if (!ack_hold && req_age >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else begin
          rd_addr_q.push_back(mem_addr);
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 8'h00;
        end
      end
    end
  end

  // Transmit sink and err pulse monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (err) begin
        err_cnt++;
        err_run++;
        if (err_run > err_max_run) err_max_run = err_run;
      end else begin
        err_run = 0;
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
    err_cnt     = 0;
    err_max_run = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({tx_valid, mem_req, mem_we, err, busy} !== 5'b0 ||
        {tx_data, mem_addr, mem_wdata} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctl=%b data=%h expected ctl=00000 data=0",
               {tx_valid, mem_req, mem_we, err, busy}, {tx_data, mem_addr, mem_wdata});
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, tx_valid, mem_req, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 0000", {busy, tx_valid, mem_req, err});
    end
  endtask

  task automatic test_ping();
    bit ok;
    clear_logs();
    send_byte(8'h03);
    wait_idle(50, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ping_idle: busy still 1 expected 0"); end
    n_tests++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL ping_tx: got %0d bytes first=%h expected 1 byte 5a", tx_q.size(),
               tx_q.size() > 0 ? tx_q[0] : 8'h00);
    end
    n_tests++;
    if (err_cnt != 0) begin n_fail++; $display("FAIL ping_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_write();
    bit ok;
    logic [7:0] hdr [6] = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h00, 8'h03};
    logic [7:0] dat [3] = '{8'hAA, 8'hBB, 8'hCC};
    logic [23:0] exp_addr [3] = '{24'h001234, 24'h001235, 24'h001236};
    clear_logs();
    ack_delay = 2;
    foreach (hdr[i]) send_byte(hdr[i]);
    foreach (dat[i]) begin
      send_byte(dat[i]);
      repeat (6) @(posedge clk);
    end
    wait_idle(50, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL write_idle: busy still 1 expected 0"); end
    n_tests++;
    if (wr_addr_q.size() != 3) begin
      n_fail++;
      $display("FAIL write_count: got %0d expected 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== dat[i]) begin
          n_fail++;
          $display("FAIL write_beat%0d: got %h=%h expected %h=%h", i,
                   wr_addr_q[i], wr_data_q[i], exp_addr[i], dat[i]);
        end
      end
    end
    n_tests++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
      n_fail++;
      $display("FAIL write_ack: got %0d bytes first=%h expected 1 byte 06", tx_q.size(),
               tx_q.size() > 0 ? tx_q[0] : 8'h00);
    end
    n_tests++;
    if (err_cnt != 0) begin n_fail++; $display("FAIL write_err: got %0d expected 0", err_cnt); end

    // Zero-length write is acknowledged without touching memory.
    clear_logs();
    foreach (hdr[i]) send_byte(i == 5 ? 8'h00 : hdr[i]);
    wait_idle(50, ok);
    n_tests++;
    if (wr_addr_q.size() != 0 || tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
      n_fail++;
      $display("FAIL write_len0: got writes=%0d tx_bytes=%0d expected writes=0 tx=06",
               wr_addr_q.size(), tx_q.size());
    end
  endtask

  task automatic test_read_wrap();
    bit ok;
    int n;
    int unstable;
    logic [7:0] held;
    logic [7:0] hdr [6] = '{8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h02};
    clear_logs();
    mem_model[24'hFFFFFF] = 8'h3C;
    mem_model[24'h000000] = 8'hC3;
    ack_delay = 2;
    tx_ready  = 1'b0;
    foreach (hdr[i]) send_byte(hdr[i]);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!tx_valid) begin n_fail++; $display("FAIL read_txvalid: got 0 expected 1 within 50 cycles"); end
    held = tx_data;
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== held) unstable++;
    end
    n_tests++;
    if (unstable != 0 || held !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_stall_stable: got %0d changes byte=%h expected 0 changes byte=3c",
               unstable, held);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle(100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL read_idle: busy still 1 expected 0"); end
    n_tests++;
    if (tx_q.size() != 3 || tx_q[0] !== 8'h3C || tx_q[1] !== 8'hC3 || tx_q[2] !== 8'h06) begin
      n_fail++;
      $display("FAIL read_tx_seq: got %0d bytes expected 3c c3 06", tx_q.size());
    end
    n_tests++;
    if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 24'hFFFFFF || rd_addr_q[1] !== 24'h000000) begin
      n_fail++;
      $display("FAIL read_addr_wrap: got %0d reads first=%h expected ffffff then 000000",
               rd_addr_q.size(), rd_addr_q.size() > 0 ? rd_addr_q[0] : 24'h0);
    end
  endtask

  task automatic test_bad_opcode();
    bit ok;
    clear_logs();
    send_byte(8'h7E);
    wait_idle(50, ok);
    n_tests++;
    if (err_cnt != 1 || err_max_run != 1) begin
      n_fail++;
      $display("FAIL badop_err: got pulses=%0d width=%0d expected 1 and 1", err_cnt, err_max_run);
    end
    n_tests++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin
      n_fail++;
      $display("FAIL badop_nak: got %0d bytes first=%h expected 1 byte 15", tx_q.size(),
               tx_q.size() > 0 ? tx_q[0] : 8'h00);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [7:0] hdr [6] = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02};
    clear_logs();
    ack_hold = 1'b1;
    foreach (hdr[i]) send_byte(hdr[i]);
    send_byte(8'hAA);
    repeat (3) @(posedge clk);
    send_byte(8'hBB);
    repeat (3) @(posedge clk);
    ack_hold = 1'b0;
    wait_idle(50, ok);
    n_tests++;
    if (err_cnt != 1 || err_max_run != 1) begin
      n_fail++;
      $display("FAIL overrun_err: got pulses=%0d width=%0d expected 1 and 1", err_cnt, err_max_run);
    end
    n_tests++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin
      n_fail++;
      $display("FAIL overrun_nak: got %0d bytes first=%h expected 1 byte 15", tx_q.size(),
               tx_q.size() > 0 ? tx_q[0] : 8'h00);
    end
    n_tests++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 24'h000010 || wr_data_q[0] !== 8'hAA) begin
      n_fail++;
      $display("FAIL overrun_write: got %0d writes expected one write 000010=aa", wr_addr_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    clear_logs();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 300);
    n_tests++;
    if (!err || n < 99 || n > 103) begin
      n_fail++;
      $display("FAIL timeout_delay: got err=%b after %0d cycles expected err near 101 cycles", err, n);
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || tx_q.size() != 0 || err_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_quiet: got busy=%b tx_bytes=%0d errs=%0d expected 0 0 1",
               busy, tx_q.size(), err_cnt);
    end
    clear_logs();
    send_byte(8'h03);
    wait_idle(50, ok);
    n_tests++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL timeout_ping: got %0d bytes expected 1 byte 5a", tx_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int n;
    logic [7:0] hdr [6] = '{8'h02, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01};
    clear_logs();
    mem_model[24'h000040] = 8'h99;
    ack_hold = 1'b1;
    foreach (hdr[i]) send_byte(hdr[i]);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 24'h000040) begin
      n_fail++;
      $display("FAIL midread_req: got req=%b addr=%h expected 1 000040", mem_req, mem_addr);
    end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({tx_valid, mem_req, mem_we, err, busy} !== 5'b0 ||
        {tx_data, mem_addr, mem_wdata} !== 40'h0) begin
      n_fail++;
      $display("FAIL midread_reset: got ctl=%b data=%h expected all 0",
               {tx_valid, mem_req, mem_we, err, busy}, {tx_data, mem_addr, mem_wdata});
    end
    @(posedge clk); #1 reset = 1'b0;
    ack_hold = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    send_byte(8'h03);
    wait_idle(50, ok);
    n_tests++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h5A || rd_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL midread_ping: got %0d bytes reads=%0d expected 1 byte 5a and no reads",
               tx_q.size(), rd_addr_q.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_ping();
    test_write();
    test_read_wrap();
    test_bad_opcode();
    test_overrun();
    test_timeout();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2700000; inter-byte timeout in clk cycles (100 ms at 27 MHz).
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rx_data  in  8  byte from UART receiver, valid only with rx_valid.
REQ-005 rx_valid  in  1  one-cycle pulse per received byte; no backpressure.
REQ-006 tx_data  out  8  byte to UART transmitter.
REQ-007 tx_valid  out  1  tx_data valid; held until accepted.
REQ-008 tx_ready  in  1  transmitter can accept; transfer = tx_valid & tx_ready.
REQ-009 mem_req  out  1  memory access request.
REQ-010 mem_we  out  1  1 = write, 0 = read.
REQ-011 mem_addr  out  24  byte address.
REQ-012 mem_wdata  out  8  write data.
REQ-013 mem_rdata  in  8  read data, valid in mem_ack cycle.
REQ-014 mem_ack  in  1  completes current request.
REQ-015 busy  out  1  high whenever state != IDLE.
REQ-016 err  out  1  one-cycle pulse on any frame error.

Function
REQ-017 Frame = opcode byte; WRITE 0x01 and READ 0x02 followed by 5 header bytes addr[23:16], addr[15:8], addr[7:0], len[15:8], len[7:0]; PING 0x03 has no header.
REQ-018 States: IDLE, HDR, WDATA, WMEM, RMEM, RSEND, RESP.
REQ-019 IDLE: rx_valid with 0x01/0x02 -> HDR; 0x03 -> RESP with 0x5A; any other -> RESP with NAK 0x15 plus err pulse.
REQ-020 HDR: after 5th header byte, WRITE -> WDATA (len>0) or RESP with ACK 0x06 (len=0); READ -> RMEM (len>0) or RESP with 0x06 (len=0).
REQ-021 WDATA: each data byte -> WMEM, mem_req=1, mem_we=1, mem_wdata=byte, mem_addr=current address.
REQ-022 WMEM: on mem_ack, mem_req drops next cycle, address +1, remaining len -1; len reaches 0 -> RESP with 0x06, else WDATA.
REQ-023 rx_valid while in WMEM (request not yet acked, ack cycle included) = overrun: drop request after ack, err pulse, RESP with 0x15.
REQ-024 RMEM: mem_req=1, mem_we=0; on mem_ack capture mem_rdata -> RSEND.
REQ-025 RSEND: present captured byte on tx; on transfer address +1, len -1; len 0 -> RESP with 0x06, else RMEM.
REQ-026 RESP: present response byte; on transfer -> IDLE.
REQ-027 rx_valid ignored (byte dropped, no error) in RMEM, RSEND, RESP.
REQ-028 mem_req/mem_we/mem_addr/mem_wdata stable from assertion until mem_ack; mem_ack allowed in the same cycle as mem_req rises; next request no earlier than cycle after ack.
REQ-029 tx_valid/tx_data stable until transfer; tx_valid deasserts in cycle after transfer.
REQ-030 Address 24-bit, wraps 0xFFFFFF -> 0x000000; len 16-bit unsigned, max 65535 bytes.
REQ-031 Timeout counter cleared on each rx_valid and on HDR/WDATA entry; reaching TIMEOUT_CYCLES in HDR or WDATA -> IDLE, err pulse, no response byte.
REQ-032 err pulses exactly one cycle per error event.

Reset
REQ-033 Reset asserted: state IDLE; tx_valid, mem_req, mem_we, err, busy = 0; tx_data, mem_addr, mem_wdata = 0; counters 0.
REQ-034 Reset mid-frame or mid-request aborts immediately; outstanding memory request abandoned, no response sent.

Structure
REQ-035 Shared package uart_cmd_pkg holds opcode constants (0x01/0x02/0x03), response constants (ACK 0x06, NAK 0x15, PONG 0x5A) and the state enum.
REQ-036 Single module, no sub-module; timeout counter and FSM inline.

Verification
REQ-037 PING: rx 0x03 -> exactly one tx byte 0x5A, busy low afterwards, no err.
REQ-038 WRITE: rx 01 00 12 34 00 03 AA BB CC, mem_ack 2 cycles after each req -> writes 0x001234=AA, 0x001235=BB, 0x001236=CC, then tx 0x06.
REQ-039 READ wrap: memory preloaded, rx 02 FF FF FF 00 02 -> reads at 0xFFFFFF then 0x000000, tx two data bytes then 0x06; tx_ready held low 50 cycles and tx_data stays stable.
REQ-040 Error: rx 0x7E -> err one cycle, tx 0x15; WRITE with mem_ack withheld while next byte arrives -> err, tx 0x15.
REQ-041 Timeout (TIMEOUT_CYCLES=100): rx 01 00 00 then silence -> IDLE after 100 cycles, err pulse, no tx byte; subsequent PING answered 0x5A.
REQ-042 Reset asserted mid-READ with mem_req high -> all outputs 0 same cycle, state IDLE; PING after release answered 0x5A.
